// File: rtl/data_ram_resp.sv
// Data-side RAM responder for the MEM stage: byte-lane-masked writes, full-word reads.
// Define DATA_RAM_WAITSTATE_EN for the IDLE/WAIT/RESP wait-state FSM with stallreq; otherwise zero-wait.
module data_ram_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack,
    output logic        err,
    output logic        stallreq
);

    logic [31:0]       mem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] idx;
    logic              sel_ok;
    logic              do_write;
    logic              unused_addr_bits;

    assign idx              = addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

    // Only contiguous, non-empty lane patterns are accepted.
    always_comb begin
        sel_ok = 1'b0;
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b0110, 4'b1100,
            4'b0111, 4'b1110, 4'b1111: sel_ok = 1'b1;
            default:                   sel_ok = 1'b0;
        endcase
    end

    // Array contents survive reset; lanes without sel keep their old value.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (sel[k]) begin
                    mem[idx][8*k +: 8] <= data_i[8*k +: 8];
                end
            end
        end
    end

`ifdef DATA_RAM_WAITSTATE_EN

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic [31:0] rd_word;
    logic        resp_err;
    logic        enter_resp;

    assign enter_resp = (next_state == RESP) && (state != RESP) && !rst;
    assign do_write   = enter_resp && we && sel_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rd_word  <= 32'd0;
            resp_err <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && ce && WAIT_CYCLES > 0) begin
                cnt <= 4'(WAIT_CYCLES - 1);
            end else if (state == WAIT && ce && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Request is sampled once, on the edge that enters RESP.
            if (enter_resp) begin
                rd_word  <= (!we && sel_ok) ? mem[idx] : 32'd0;
                resp_err <= !sel_ok;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ce) begin
                    next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!ce) begin
                    next_state = IDLE;
                end else if (cnt == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ack      = (state == RESP);
        data_o   = ack ? rd_word : 32'd0;
        err      = ack && resp_err;
        stallreq = ce && (state != RESP) && !rst;
    end

`else

    assign do_write = ce && we && sel_ok && !rst;

    always_comb begin
        ack      = ce && !rst;
        err      = ack && !sel_ok;
        data_o   = (ack && !we && sel_ok) ? mem[idx] : 32'd0;
        stallreq = 1'b0;
    end

`endif

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed self-checking bench for data_ram_resp; adapts its latency expectations
// to whether DATA_RAM_WAITSTATE_EN is defined.
module tb_data_ram_resp;

    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 2;
`ifdef DATA_RAM_WAITSTATE_EN
    localparam int EXP_LAT     = WAIT_CYCLES + 1;
`else
    localparam int EXP_LAT     = 0;
`endif

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack;
    logic        err;
    logic        stallreq;

    int checks = 0;
    int errors = 0;

    data_ram_resp #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .we       (we),
        .addr     (addr),
        .sel      (sel),
        .data_i   (data_i),
        .data_o   (data_o),
        .ack      (ack),
        .err      (err),
        .stallreq (stallreq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic c, input logic w, input logic [31:0] a,
                                  input logic [3:0] s, input logic [31:0] d);
        ce     = c;
        we     = w;
        addr   = a;
        sel    = s;
        data_i = d;
    endtask

    // Presents one request held until ack (bounded), then returns to idle inputs.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [3:0] s,
                             input logic [31:0] d, output logic [31:0] rd, output logic got_err,
                             output int lat, output int stalls, output logic stall_at_ack);
        apply_stimulus(1'b1, w, a, s, d);
        lat          = -1;
        stalls       = 0;
        rd           = 32'hxxxxxxxx;
        got_err      = 1'bx;
        stall_at_ack = 1'bx;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                lat          = c;
                rd           = data_o;
                got_err      = err;
                stall_at_ack = stallreq;
                break;
            end
            if (stallreq === 1'b1) stalls++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 1'b0, 32'd0, 4'b0000, 32'd0);
    endtask

    task automatic check_access(input string tag, input logic w, input logic [31:0] a,
                                input logic [3:0] s, input logic [31:0] d,
                                input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        got_err;
        int          lat;
        int          stalls;
        logic        stall_at_ack;
        do_access(w, a, s, d, rd, got_err, lat, stalls, stall_at_ack);
        check_output({tag, "_lat"},    32'(lat),           32'(EXP_LAT));
        check_output({tag, "_data"},   rd,                 exp_rd);
        check_output({tag, "_err"},    {31'd0, got_err},   {31'd0, exp_err});
        check_output({tag, "_stalls"}, 32'(stalls),        32'(EXP_LAT));
        check_output({tag, "_stall_at_ack"}, {31'd0, stall_at_ack}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 32'd0, 4'b0000, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_ack",   {31'd0, ack},      32'd0);
        check_output("reset_err",   {31'd0, err},      32'd0);
        check_output("reset_stall", {31'd0, stallreq}, 32'd0);
        check_output("reset_data",  data_o,            32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("idle_ack", {31'd0, ack}, 32'd0);

        // Full-word write then read-back
        check_access("wr_word", 1'b1, 32'h40, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
        check_access("rd_word", 1'b0, 32'h40, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        check_output("idle_after_ack", {31'd0, ack}, 32'd0);

        // Byte and halfword lane writes
        check_access("wr_byte1", 1'b1, 32'h41, 4'b0010, 32'h55555555, 32'h0, 1'b0);
        check_access("rd_byte1", 1'b0, 32'h40, 4'b1111, 32'h0, 32'hDEAD55EF, 1'b0);
        check_access("wr_half1", 1'b1, 32'h42, 4'b1100, 32'h12341234, 32'h0, 1'b0);
        check_access("rd_half1", 1'b0, 32'h40, 4'b1111, 32'h0, 32'h123455EF, 1'b0);
        check_access("rd_sel1",  1'b0, 32'h43, 4'b0001, 32'h0, 32'h123455EF, 1'b0);

        // Illegal lane patterns
        check_access("wr_ill0101", 1'b1, 32'h40, 4'b0101, 32'hFFFFFFFF, 32'h0, 1'b1);
        check_access("rd_after_ill", 1'b0, 32'h40, 4'b1111, 32'h0, 32'h123455EF, 1'b0);
        check_access("rd_ill1001", 1'b0, 32'h40, 4'b1001, 32'h0, 32'h0, 1'b1);
        check_access("rd_ill0000", 1'b0, 32'h40, 4'b0000, 32'h0, 32'h0, 1'b1);
        check_access("wr_ill1011", 1'b1, 32'h40, 4'b1011, 32'h00000000, 32'h0, 1'b1);
        check_access("rd_after_ill2", 1'b0, 32'h40, 4'b1111, 32'h0, 32'h123455EF, 1'b0);

        check_access("wr_80", 1'b1, 32'h80, 4'b1111, 32'h0BADF00D, 32'h0, 1'b0);

`ifdef DATA_RAM_WAITSTATE_EN
        // Abort: ce dropped while waiting, no write and no ack
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 1'b1, 32'h80, 4'b1111, 32'hFFFFFFFF);
        @(negedge clk);
        check_output("abort_stall0", {31'd0, stallreq}, 32'd1);
        check_output("abort_ack0",   {31'd0, ack},      32'd0);
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_output("abort_no_ack", {31'd0, ack}, 32'd0);
            @(posedge clk);
            #1;
        end
        check_access("rd_after_abort", 1'b0, 32'h80, 4'b1111, 32'h0, 32'h0BADF00D, 1'b0);

        // Reset mid-access
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 1'b1, 32'h80, 4'b1111, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply_stimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        @(negedge clk);
        check_output("rst_mid_ack",   {31'd0, ack},      32'd0);
        check_output("rst_mid_data",  data_o,            32'd0);
        check_output("rst_mid_stall", {31'd0, stallreq}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_output("rst_mid_no_ack", {31'd0, ack}, 32'd0);
        end
        @(posedge clk);
        #1;
`endif
        check_access("rd_80", 1'b0, 32'h80, 4'b1111, 32'h0, 32'h0BADF00D, 1'b0);

        // Address wraps modulo depth; low byte-offset bits are ignored
        check_access("wr_wrap", 1'b1, 32'h00001000, 4'b1111, 32'hA5A5A5A5, 32'h0, 1'b0);
        check_access("rd_wrap", 1'b0, 32'h00000000, 4'b1111, 32'h0, 32'hA5A5A5A5, 1'b0);
        check_access("rd_wrap_hi", 1'b0, 32'hFFFF1003, 4'b1111, 32'h0, 32'hA5A5A5A5, 1'b0);
        check_access("rd_40_final", 1'b0, 32'h40, 4'b1111, 32'h0, 32'h123455EF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
- Data-side memory responder: the RAM end of the MEM stage's load/store interface.
- Accepts chip-enable, write-enable, word address, byte-lane select and write data from the MEM stage.
- Performs byte-lane-masked writes into an internal word array; returns full 32-bit read words, which the MEM stage then aligns and extends itself.
- Optionally inserts wait states and raises a stall request toward the pipeline controller.

Parameters:
- ADDR_W, 10, word-index width; array depth = 2**ADDR_W words of 32 bits.
- WAIT_CYCLES, 2, extra wait cycles per access. Used only when DATA_RAM_WAITSTATE_EN is defined; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high (1 = RstEnable).
- ce  in  1  chip enable; 1 = access requested this cycle.
- we  in  1  1 = write, 0 = read; valid only when ce=1.
- addr  in  32  byte address; word index = addr[ADDR_W+1:2]; addr[1:0] and addr[31:ADDR_W+2] ignored (address wraps modulo depth).
- sel  in  4  byte-lane enables; sel[k] covers data bits [8k+7:8k].
- data_i  in  32  write data, pre-replicated or shifted onto lanes by the MEM stage.
- data_o  out  32  read word.
- ack  out  1  access completes this cycle.
- err  out  1  access rejected for an illegal lane pattern; qualified by ack.
- stallreq  out  1  request to freeze the pipeline until ack.

Behaviour:
- Legal sel values: contiguous non-empty patterns 0001, 0010, 0100, 1000, 0011, 0110, 1100, 0111, 1110, 1111.
- Illegal sel values: 0000, 0101, 1001, 1010, 1011, 1101. An illegal write performs no write. An illegal read returns data_o = 0. Either way err = 1 together with ack.
- Reads return the whole word regardless of sel.
- Write commit: for each lane with sel[k] = 1, mem[idx][8k+7:8k] <= data_i[8k+7:8k]; all other lanes keep their value.
- Array contents are never cleared by rst.
- Outputs when ack = 0: data_o = 0, err = 0.
- Write ack: data_o = 0.
- Reset: outputs ack = 0, err = 0, stallreq = 0, data_o = 0; FSM in IDLE; wait counter = 0.
- Zero-wait mode (macro undefined):
  - Purely combinational response: ack = ce; stallreq = 0 always.
  - data_o = mem[idx] when ce & ~we & legal sel.
  - Write commits at the rising edge ending the cycle in which ce & we & legal sel.
  - A read following a write to the same word sees the new data.
  - No FSM is instantiated.
- Wait-state FSM (macro defined). States IDLE, WAIT, RESP; 4-bit counter cnt.
  - IDLE: on ce=1 → WAIT with cnt = WAIT_CYCLES-1 if WAIT_CYCLES > 0, else → RESP. Otherwise stay in IDLE.
  - WAIT: on ce=0 → IDLE (abort: no write, no ack). If cnt = 0 → RESP, else cnt decrements.
  - On the transition into RESP: write committed, read word registered.
  - RESP: ack = 1; data_o = registered word (read) or 0 (write); err per sel. Next state is always IDLE, even if ce stays 1; a held ce is treated as a new access.
  - stallreq = ce & (state != RESP), combinational.
  - Latency: a request first presented in cycle 0 gets ack in cycle WAIT_CYCLES+1. stallreq is high in cycles 0..WAIT_CYCLES and low in the ack cycle.
  - The requester holds addr, we, sel and data_i stable from request to ack; they are sampled at the edge entering RESP.
  - Reset mid-access: rst=1 in any state → IDLE next edge, no write, ack = 0.
  - Simultaneous rst and ce: rst wins.

Optional Feature:
- Macro DATA_RAM_WAITSTATE_EN.
- Defined: IDLE/WAIT/RESP FSM, WAIT_CYCLES latency, stallreq active.
- Undefined: single-cycle combinational-read / clocked-write responder, stallreq tied 0, WAIT_CYCLES ignored.

Test Plan:
1. Macro off. Write ce=1, we=1, addr=0x40, sel=1111, data_i=0xDEADBEEF. Next cycle read addr=0x40 → same-cycle ack=1, data_o=0xDEADBEEF, stallreq=0.
2. Macro off, after test 1. Byte write addr=0x41, sel=0010, data_i=0x55555555, then read 0x40 → 0xDEAD55EF. Then halfword write sel=1100, data_i=0x12341234 → read 0x1234_55EF.
3. Macro on, WAIT_CYCLES=2. Read 0x40 with inputs held → stallreq=1 in cycles 0,1,2; ack=1, stallreq=0, data_o=0x123455EF in cycle 3; IDLE in cycle 4.
4. Illegal lanes. Write sel=0101, data_i=0xFFFFFFFF to 0x40 → ack=1 with err=1; subsequent read returns 0x123455EF unchanged. Same with macro off: err=1 in the request cycle.
5. Abort and reset. Macro on: write request to 0x80, drop ce in cycle 1 → no ack, mem[0x80] unchanged, back in IDLE. Repeat with rst=1 in cycle 1 → outputs 0 next cycle, no write.
6. Wrap-around. ADDR_W=10: write 0xA5A5A5A5 to addr=0x00001000 → read addr=0x00000000 returns 0xA5A5A5A5.
